// File: rtl/centroid_sched_pkg.sv
// Shared types and the centroid arithmetic for the LiDAR feature calculator.
// bbox_t packs six signed Q16.16 coordinates with min_x in the least
// significant bits; compute_centroid is pure combinational and reusable.
package centroid_sched_pkg;

  localparam int unsigned COORD_W = 32;
  localparam int unsigned BBOX_W  = 6 * COORD_W;

  typedef logic signed [COORD_W-1:0] coord_t;

  // Field order is MSB first, so min_x lands in bits [31:0].
  typedef struct packed {
    coord_t max_z;
    coord_t max_y;
    coord_t max_x;
    coord_t min_z;
    coord_t min_y;
    coord_t min_x;
  } bbox_t;

  typedef struct packed {
    logic   error;
    coord_t z;
    coord_t y;
    coord_t x;
  } centroid_t;

  // Midpoint via a widened sum: no overflow wrap, arithmetic floor on the halve.
  function automatic coord_t axis_mid(input coord_t lo, input coord_t hi);
    logic [COORD_W:0] sum;
    sum = {lo[COORD_W-1], lo} + {hi[COORD_W-1], hi};
    return sum[COORD_W:1];
  endfunction

  function automatic centroid_t compute_centroid(input bbox_t b);
    centroid_t c;
    c.error = (b.min_x > b.max_x) || (b.min_y > b.max_y) || (b.min_z > b.max_z);
    if (c.error) begin
      c.x = '0;
      c.y = '0;
      c.z = '0;
    end else begin
      c.x = axis_mid(b.min_x, b.max_x);
      c.y = axis_mid(b.min_y, b.max_y);
      c.z = axis_mid(b.min_z, b.max_z);
    end
    return c;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter owning its search pointer.
// Ports: clk, rst (sync, active-high), req (N requests), advance (grant is
// taken this cycle), grant_c (one-hot, combinational), grant_id_c (index).
module rr_arbiter #(
  parameter  int unsigned N     = 4,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     grant_c,
  output logic [IDX_W-1:0] grant_id_c
);

  localparam int unsigned DW = $clog2(2 * N);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [2*N-1:0]   req_dbl;
  logic [DW-1:0]    idx;
  logic             found;

  // Doubled request vector turns the wrap-around search into a linear scan.
  always_comb begin
    req_dbl    = {req, req};
    found      = 1'b0;
    grant_id_c = '0;
    idx        = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = DW'(ptr_q) + DW'(i);
      if (!found && req_dbl[idx]) begin
        found      = 1'b1;
        grant_id_c = (idx >= DW'(N)) ? IDX_W'(idx - DW'(N)) : IDX_W'(idx);
      end
    end
    grant_c = found ? (N'(1) << grant_id_c) : '0;
    ptr_d   = ptr_q;
    if (advance && found) begin
      ptr_d = (grant_id_c == IDX_W'(N - 1)) ? '0 : grant_id_c + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/centroid_scheduler.sv
// Shares one centroid datapath between N_REQ cluster engines.
// Ports: req_valid/req_ready/req_bbox (per-engine box handshake, ready is
// combinational in IDLE), res_* (registered result with id and error flag),
// busy (not idle), done_count/err_count (saturating statistics).
module centroid_scheduler
  import centroid_sched_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*BBOX_W-1:0] req_bbox,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [ID_W-1:0]         res_id,
  output logic [COORD_W-1:0]      res_centroid_x,
  output logic [COORD_W-1:0]      res_centroid_y,
  output logic [COORD_W-1:0]      res_centroid_z,
  output logic                    res_error,
  output logic                    busy,
  output logic [CNT_W-1:0]        done_count,
  output logic [CNT_W-1:0]        err_count
);

  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_OUT} state_e;

  state_e           state_q, state_d;
  bbox_t            bbox_q, bbox_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic             res_valid_q, res_valid_d;
  logic [ID_W-1:0]  res_id_q, res_id_d;
  centroid_t        res_q, res_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] done_q, done_d;
  logic [CNT_W-1:0] err_q, err_d;

  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_id;
  logic             take_c;

  // A handshake can only complete in IDLE and never during reset.
  assign take_c    = (state_q == ST_IDLE) && !rst && (|req_valid);
  assign req_ready = take_c ? grant : '0;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk        (clk),
    .rst        (rst),
    .req        (req_valid),
    .advance    (take_c),
    .grant_c    (grant),
    .grant_id_c (grant_id)
  );

  // Next-state and datapath capture.
  always_comb begin
    state_d     = state_q;
    bbox_d      = bbox_q;
    id_d        = id_q;
    res_valid_d = res_valid_q;
    res_id_d    = res_id_q;
    res_d       = res_q;
    done_d      = done_q;
    err_d       = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (take_c) begin
          for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant[i]) bbox_d = bbox_t'(req_bbox[i*BBOX_W +: BBOX_W]);
          end
          id_d    = grant_id;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        res_d       = compute_centroid(bbox_q);
        res_id_d    = id_q;
        res_valid_d = 1'b1;
        state_d     = ST_OUT;
      end
      ST_OUT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          done_d      = (done_q == '1) ? done_q : done_q + CNT_W'(1);
          if (res_q.error) err_d = (err_q == '1) ? err_q : err_q + CNT_W'(1);
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bbox_q      <= '0;
      id_q        <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      bbox_q      <= bbox_d;
      id_q        <= id_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_q       <= res_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign res_valid      = res_valid_q;
  assign res_id         = res_id_q;
  assign res_centroid_x = res_q.x;
  assign res_centroid_y = res_q.y;
  assign res_centroid_z = res_q.z;
  assign res_error      = res_q.error;
  assign busy           = busy_q;
  assign done_count     = done_q;
  assign err_count      = err_q;

endmodule

// File: tb/tb_centroid_scheduler.sv
// Directed bench for centroid_scheduler: vector table plus round-robin,
// backpressure, mid-operation reset and counter saturation sequences.
module tb_centroid_scheduler;
  import centroid_sched_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned IW = 2;
  localparam int unsigned CW = 4;  // small counters so saturation is reachable

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*192-1:0]  req_bbox;
  logic              res_valid;
  logic              res_ready;
  logic [IW-1:0]     res_id;
  logic [31:0]       res_centroid_x, res_centroid_y, res_centroid_z;
  logic              res_error;
  logic              busy;
  logic [CW-1:0]     done_count, err_count;

  int total = 0;
  int bad   = 0;
  int exp_done = 0;
  int exp_err  = 0;

  always #5 clk = ~clk;

  centroid_scheduler #(.N_REQ(N), .ID_W(IW), .CNT_W(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_bbox       (req_bbox),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_id         (res_id),
    .res_centroid_x (res_centroid_x),
    .res_centroid_y (res_centroid_y),
    .res_centroid_z (res_centroid_z),
    .res_error      (res_error),
    .busy           (busy),
    .done_count     (done_count),
    .err_count      (err_count)
  );

  typedef struct {
    int unsigned  id;
    logic [191:0] bbox;
    logic [31:0]  ex, ey, ez;
    logic         ee;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [191:0] mk(input logic [31:0] mnx, mny, mnz, mxx, mxy, mxz);
    return {mxz, mxy, mxx, mnz, mny, mnx};
  endfunction

  function automatic int sat(input int v);
    return (v < 15) ? v + 1 : 15;
  endfunction

  // One full transaction from IDLE; entered and left at posedge+1.
  task automatic run_one(input vec_t v, input string tag);
    req_bbox[v.id*192 +: 192] = v.bbox;
    req_valid = '0;
    req_valid[v.id] = 1'b1;
    #1;
    chk($sformatf("%s.ready", tag), 64'(req_ready), 64'(1 << v.id));
    @(posedge clk); #1;
    req_valid = '0;
    chk($sformatf("%s.calc_ready", tag), 64'(req_ready), 64'd0);
    chk($sformatf("%s.calc_busy", tag), 64'(busy), 64'd1);
    chk($sformatf("%s.calc_valid", tag), 64'(res_valid), 64'd0);
    @(posedge clk); #1;
    chk($sformatf("%s.valid", tag), 64'(res_valid), 64'd1);
    chk($sformatf("%s.id", tag), 64'(res_id), 64'(v.id));
    chk($sformatf("%s.cx", tag), 64'(res_centroid_x), 64'(v.ex));
    chk($sformatf("%s.cy", tag), 64'(res_centroid_y), 64'(v.ey));
    chk($sformatf("%s.cz", tag), 64'(res_centroid_z), 64'(v.ez));
    chk($sformatf("%s.err", tag), 64'(res_error), 64'(v.ee));
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    exp_done = sat(exp_done);
    if (v.ee) exp_err = sat(exp_err);
    chk($sformatf("%s.drop", tag), 64'(res_valid), 64'd0);
    chk($sformatf("%s.keep_cx", tag), 64'(res_centroid_x), 64'(v.ex));
    chk($sformatf("%s.done_cnt", tag), 64'(done_count), 64'(exp_done));
    chk($sformatf("%s.err_cnt", tag), 64'(err_count), 64'(exp_err));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1, mk(32'h0001_0000, 0, 0, 32'h0003_0000, 0, 0), 32'h0002_0000, 0, 0, 1'b0};
    vecs[1] = '{0, mk(32'hFFFD_0000, 32'hFFFF_FFFF, 0, 32'h0001_0000, 0, 0),
                32'hFFFF_0000, 32'hFFFF_FFFF, 0, 1'b0};
    vecs[2] = '{2, mk(0, 0, 32'h7FFF_0000, 0, 0, 32'h7FFF_0000), 0, 0, 32'h7FFF_0000, 1'b0};
    vecs[3] = '{3, mk(32'h8000_0000, 0, 0, 32'h8000_0000, 0, 0), 32'h8000_0000, 0, 0, 1'b0};
    vecs[4] = '{2, mk(32'h0001_0000, 32'h0005_0000, 0, 32'h0003_0000, 32'h0002_0000, 0),
                0, 0, 0, 1'b1};
    vecs[5] = '{3, mk(32'h0000_8000, 32'hFFFF_0000, 32'h1, 32'h0001_0000, 32'h0003_0000, 32'h2),
                32'h0000_C000, 32'h0001_0000, 32'h1, 1'b0};

    // Reset: no handshake even with a request present.
    rst = 1'b1; req_valid = '0; res_ready = 1'b0; req_bbox = '0;
    repeat (2) @(posedge clk);
    #1;
    req_valid = 4'b0001;
    #1;
    chk("rst.ready", 64'(req_ready), 64'd0);
    req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst.valid", 64'(res_valid), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.id", 64'(res_id), 64'd0);
    chk("rst.cx", 64'(res_centroid_x), 64'd0);
    chk("rst.err", 64'(res_error), 64'd0);
    chk("rst.done", 64'(done_count), 64'd0);
    chk("rst.errcnt", 64'(err_count), 64'd0);

    for (int i = 0; i < 6; i++) run_one(vecs[i], $sformatf("v%0d", i));

    // Round-robin with all engines requesting; backpressure on the third result.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_done = 0; exp_err = 0;
    for (int i = 0; i < 4; i++) req_bbox[i*192 +: 192] = mk(i << 16, 0, 0, i << 16, 0, 0);
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      int e;
      e = k % 4;
      #1;
      chk($sformatf("rr%0d.ready", k), 64'(req_ready), 64'(1 << e));
      @(posedge clk); #1;
      chk($sformatf("rr%0d.calc_ready", k), 64'(req_ready), 64'd0);
      @(posedge clk); #1;
      chk($sformatf("rr%0d.valid", k), 64'(res_valid), 64'd1);
      chk($sformatf("rr%0d.id", k), 64'(res_id), 64'(e));
      chk($sformatf("rr%0d.cx", k), 64'(res_centroid_x), 64'(e << 16));
      if (k == 2) begin
        for (int h = 0; h < 5; h++) begin
          @(posedge clk); #1;
          chk($sformatf("hold%0d.valid", h), 64'(res_valid), 64'd1);
          chk($sformatf("hold%0d.id", h), 64'(res_id), 64'(e));
          chk($sformatf("hold%0d.cx", h), 64'(res_centroid_x), 64'(e << 16));
          chk($sformatf("hold%0d.ready", h), 64'(req_ready), 64'd0);
        end
      end
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      exp_done++;
    end
    req_valid = '0;
    chk("rr.done", 64'(done_count), 64'(exp_done));

    // Reset while in CALC: box from engine 2 is dropped, pointer returns to 0.
    req_bbox[2*192 +: 192] = mk(32'h000A_0000, 0, 0, 32'h000C_0000, 0, 0);
    req_valid = 4'b0100;
    #1;
    chk("abort.ready", 64'(req_ready), 64'b0100);
    @(posedge clk); #1;
    req_valid = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_done = 0; exp_err = 0;
    chk("abort.valid", 64'(res_valid), 64'd0);
    chk("abort.busy", 64'(busy), 64'd0);
    chk("abort.done", 64'(done_count), 64'd0);
    @(posedge clk); #1;
    chk("abort.no_result", 64'(res_valid), 64'd0);
    req_bbox[1*192 +: 192] = mk(32'h0004_0000, 0, 0, 32'h0006_0000, 0, 0);
    req_bbox[3*192 +: 192] = mk(32'h0010_0000, 0, 0, 32'h0010_0000, 0, 0);
    req_valid = 4'b1010;
    #1;
    chk("post.ready", 64'(req_ready), 64'b0010);
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    chk("post.valid", 64'(res_valid), 64'd1);
    chk("post.id", 64'(res_id), 64'd1);
    chk("post.cx", 64'(res_centroid_x), 64'h0005_0000);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    exp_done = sat(exp_done);
    chk("post.done", 64'(done_count), 64'(exp_done));
    repeat (3) @(posedge clk);
    #1;
    chk("post.idle", 64'(res_valid), 64'd0);

    // Drive both counters past their ceiling.
    for (int i = 0; i < 17; i++) run_one(vecs[4], $sformatf("sat%0d", i));
    chk("sat.done", 64'(done_count), 64'd15);
    chk("sat.err", 64'(err_count), 64'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/centroid_scheduler.md
Name: centroid_scheduler

Overview:
- Shares one centroid datapath between N_REQ cluster engines in the LiDAR feature calculator.
- Each engine presents a Q16.16 axis-aligned bounding box (min/max x,y,z) with a valid/ready handshake.
- The scheduler arbitrates round-robin, computes the centroid and an ordering-error flag, and returns the result tagged with the requester ID.
- Saturating statistics counters are maintained for the feature-extractor status registers.

Parameters:
- N_REQ, 4, number of requesting cluster engines (2..8).
- ID_W, 2, requester ID width; must equal max(1, clog2(N_REQ)).
- CNT_W, 16, width of statistics counters.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester bounding box valid.
- req_ready  out  N_REQ  per-requester accept; one-hot or zero.
- req_bbox  in  N_REQ*192  per requester, LSB first: min_x, min_y, min_z, max_x, max_y, max_z; each signed 32-bit Q16.16.
- res_valid  out  1  result valid.
- res_ready  in  1  downstream accept.
- res_id  out  ID_W  index of the requester that produced the result.
- res_centroid_x / res_centroid_y / res_centroid_z  out  32 each  signed Q16.16 centroid.
- res_error  out  1  ordering error: any min > max.
- busy  out  1  high whenever state != IDLE.
- done_count  out  CNT_W  results accepted downstream, saturating.
- err_count  out  CNT_W  accepted results with res_error=1, saturating.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, rr pointer=0, capture regs=0, res_valid=0, res_id=0, centroids=0, res_error=0, busy=0, req_ready=0, counters=0.
- Reset mid-operation discards any in-flight box or unconsumed result; no handshake completes in the reset cycle.
- FSM states: IDLE, CALC, OUT.
- IDLE:
  - If any req_valid is set, grant the first asserted index searching from the pointer upward, wrapping at N_REQ.
  - req_ready[grant] is driven combinationally high in that cycle only. The handshake completes in the same cycle.
  - Capture the granted bbox and ID, set pointer = (grant+1) mod N_REQ, go to CALC.
  - With no valid requests, stay in IDLE and keep the pointer unchanged.
- CALC (one cycle):
  - error = (min_x>max_x) | (min_y>max_y) | (min_z>max_z), signed compares.
  - Each axis: 33-bit signed sum min+max, result = sum[32:1]. This is an arithmetic floor /2 with no overflow wrap.
  - If error is set, all three centroids = 0.
  - Register the results, set res_valid=1, go to OUT.
- OUT:
  - Hold all res_* stable while res_valid=1 and res_ready=0.
  - On res_ready=1: clear res_valid, increment done_count (and err_count if res_error), go to IDLE.
  - res_* data retains its last value after res_valid drops.
- Latency and throughput: request handshake at cycle T gives res_valid at T+2. Minimum 3 cycles per result.
- req_ready is never asserted outside IDLE. A requester holds valid and bbox stable until it sees ready.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- Fairness: a continuously requesting engine waits at most N_REQ-1 grants.

Decomposition:
- Package centroid_sched_pkg:
  - bbox_t struct with six signed 32-bit Q16.16 fields.
  - centroid_t struct with x, y, z and error.
  - Constant BBOX_W=192.
  - Function compute_centroid(bbox_t) returning centroid_t; reusable by other feature blocks.
- Sub-module rr_arbiter:
  - Parameter N.
  - Inputs: req, advance.
  - Output: one-hot grant.
  - Owns the pointer register.

Test Plan:
- Single request from req 1, min_x=0x0001_0000, max_x=0x0003_0000, y/z=0 -> handshake at T; at T+2 res_valid=1, res_id=1, cx=0x0002_0000, cy=cz=0, res_error=0; done_count=1 after accept.
- Signed and rounding case, min_x=0xFFFD_0000 (-3.0), max_x=0x0001_0000 (1.0) -> cx=0xFFFF_0000. Also min_y=0xFFFF_FFFF, max_y=0 -> cy=0xFFFF_FFFF (floor).
- Overflow guard, min_z=max_z=0x7FFF_0000 -> cz=0x7FFF_0000. Separately min_x=max_x=0x8000_0000 -> cx=0x8000_0000.
- Error case, min_y=0x0005_0000 > max_y=0x0002_0000 -> res_error=1, all centroids 0; err_count=1, done_count=1.
- All four requesters valid continuously -> grant order 0,1,2,3,0 across five results. res_ready held low 5 cycles at result 2 -> outputs stable, no new req_ready until accept.
- rst asserted for 1 cycle while in CALC with req 2 pending -> next cycle res_valid=0, busy=0, pointer=0. The following grant goes to the lowest valid index, and the aborted box produces no result.
